// File: rtl/beep_driver.sv
// beep_driver: turns the timer mux's 2-bit beep request (01 short pip, 10 long tone)
// into a timed square wave on the buzzer pin, with edge detection and preemption.
// Optional feature: define BEEP_REPEAT_EN to repeat long beeps, separated by a silent
// gap, for as long as the 10 request is held.
// During a repeat gap, beep_kind reads 00 because no tone is playing.

module beep_driver #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned LO_HALF  = 50000,
    parameter int unsigned HI_HALF  = 25000,
    parameter int unsigned SHORT_MS = 100,
    parameter int unsigned LONG_MS  = 500,
    parameter int unsigned GAP_MS   = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] bee_in,
    output logic       buzzer,
    output logic       busy,
    output logic [1:0] beep_kind,
    output logic       done
);

    localparam int unsigned HALF_MAX = (LO_HALF > HI_HALF) ? LO_HALF : HI_HALF;
    localparam int unsigned HALF_W   = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DUR_MAX  = (SHORT_MS > LONG_MS) ? SHORT_MS : LONG_MS;
    localparam int unsigned MS_MAX   = (GAP_MS > DUR_MAX) ? GAP_MS : DUR_MAX;
    localparam int unsigned MS_W     = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;

    localparam logic [HALF_W-1:0] LO_LAST    = HALF_W'(LO_HALF - 1);
    localparam logic [HALF_W-1:0] HI_LAST    = HALF_W'(HI_HALF - 1);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [MS_W-1:0]   SHORT_LAST = MS_W'(SHORT_MS - 1);
    localparam logic [MS_W-1:0]   LONG_LAST  = MS_W'(LONG_MS - 1);

    localparam logic [1:0] CODE_NONE  = 2'b00;
    localparam logic [1:0] CODE_SHORT = 2'b01;
    localparam logic [1:0] CODE_LONG  = 2'b10;

`ifdef BEEP_REPEAT_EN
    localparam logic [MS_W-1:0] GAP_LAST = MS_W'(GAP_MS - 1);
    typedef enum logic [1:0] {StIdle, StBeep, StGap} state_e;
`else
    typedef enum logic [1:0] {StIdle, StBeep} state_e;
`endif

    state_e            state;
    logic [1:0]        bee_q;
    logic [HALF_W-1:0] half_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [MS_W-1:0]   ms_cnt;

    logic trig;
    logic start;
    logic half_last;
    logic tick_last;
    logic beep_last;
`ifdef BEEP_REPEAT_EN
    logic gap_last;
    logic repeat_long;
`endif

    // Trigger detection and end-of-period decodes for the current beep.
    always_comb begin
        trig  = ((bee_in == CODE_SHORT) || (bee_in == CODE_LONG)) && (bee_in != bee_q);
        start = 1'b0;
        case (state)
            StIdle:  start = trig;
            // A short request never interrupts a long beep.
            StBeep:  start = trig && !((beep_kind == CODE_LONG) && (bee_in == CODE_SHORT));
            default: start = 1'b0;
        endcase
        half_last = (beep_kind == CODE_LONG) ? (half_cnt == HI_LAST) : (half_cnt == LO_LAST);
        tick_last = (tick_cnt == TICK_LAST);
        beep_last = tick_last &&
                    ((beep_kind == CODE_LONG) ? (ms_cnt == LONG_LAST) : (ms_cnt == SHORT_LAST));
`ifdef BEEP_REPEAT_EN
        gap_last    = tick_last && (ms_cnt == GAP_LAST);
        repeat_long = (beep_kind == CODE_LONG) && (bee_in == CODE_LONG);
`endif
    end

    // FSM with registered outputs; reset silences the buzzer asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            bee_q     <= CODE_NONE;
            half_cnt  <= '0;
            tick_cnt  <= '0;
            ms_cnt    <= '0;
            buzzer    <= 1'b0;
            busy      <= 1'b0;
            beep_kind <= CODE_NONE;
            done      <= 1'b0;
        end else begin
            bee_q <= bee_in;
            done  <= 1'b0;
            if (start) begin
                // New, preempting or same-code restart: fresh counters, tone starts high.
                state     <= StBeep;
                busy      <= 1'b1;
                beep_kind <= bee_in;
                buzzer    <= 1'b1;
                half_cnt  <= '0;
                tick_cnt  <= '0;
                ms_cnt    <= '0;
            end else begin
                case (state)
                    StBeep: begin
                        if (beep_last) begin
                            done      <= 1'b1;
                            buzzer    <= 1'b0;
                            beep_kind <= CODE_NONE;
                            half_cnt  <= '0;
                            tick_cnt  <= '0;
                            ms_cnt    <= '0;
`ifdef BEEP_REPEAT_EN
                            if (repeat_long) begin
                                state <= StGap;
                            end else begin
                                state <= StIdle;
                                busy  <= 1'b0;
                            end
`else
                            state <= StIdle;
                            busy  <= 1'b0;
`endif
                        end else begin
                            if (half_last) begin
                                buzzer   <= ~buzzer;
                                half_cnt <= '0;
                            end else begin
                                half_cnt <= half_cnt + 1'b1;
                            end
                            if (tick_last) begin
                                tick_cnt <= '0;
                                ms_cnt   <= ms_cnt + 1'b1;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
`ifdef BEEP_REPEAT_EN
                    StGap: begin
                        if (bee_in != CODE_LONG) begin
                            state    <= StIdle;
                            busy     <= 1'b0;
                            tick_cnt <= '0;
                            ms_cnt   <= '0;
                        end else if (gap_last) begin
                            state     <= StBeep;
                            beep_kind <= CODE_LONG;
                            buzzer    <= 1'b1;
                            half_cnt  <= '0;
                            tick_cnt  <= '0;
                            ms_cnt    <= '0;
                        end else if (tick_last) begin
                            tick_cnt <= '0;
                            ms_cnt   <= ms_cnt + 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_beep_driver.sv
// tb_beep_driver: table-driven vectors plus hand-written sequences; per-cycle expected
// outputs are queued as stimulus is planned and popped on each falling clock edge.

module tb_beep_driver;

    localparam int unsigned TICK_DIV = 10;
    localparam int unsigned LO_HALF  = 4;
    localparam int unsigned HI_HALF  = 2;
    localparam int unsigned SHORT_MS = 3;
    localparam int unsigned LONG_MS  = 5;
    localparam int unsigned GAP_MS   = 2;

    localparam int SHORT_CYC = SHORT_MS * TICK_DIV;
    localparam int LONG_CYC  = LONG_MS * TICK_DIV;
    localparam int GAP_CYC   = GAP_MS * TICK_DIV;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] bee_in;
    logic       buzzer;
    logic       busy;
    logic [1:0] beep_kind;
    logic       done;

    typedef struct packed {
        logic       buzzer;
        logic       busy;
        logic [1:0] kind;
        logic       done;
    } exp_t;

    typedef struct {
        logic [1:0] code;
        int         hold;
        int         total;
        int         dur;
        int         half;
        logic [1:0] kind;
    } vec_t;

    exp_t  exp_q[$];
    vec_t  vecs[4];
    int    checks = 0;
    int    errors = 0;
    int    step   = 0;
    string tag    = "";

    always #5 clk = ~clk;

    beep_driver #(
        .TICK_DIV(TICK_DIV),
        .LO_HALF (LO_HALF),
        .HI_HALF (HI_HALF),
        .SHORT_MS(SHORT_MS),
        .LONG_MS (LONG_MS),
        .GAP_MS  (GAP_MS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bee_in   (bee_in),
        .buzzer   (buzzer),
        .busy     (busy),
        .beep_kind(beep_kind),
        .done     (done)
    );

    task automatic push(input logic bz, input logic by, input logic [1:0] k, input logic d);
        exp_t e;
        e.buzzer = bz;
        e.busy   = by;
        e.kind   = k;
        e.done   = d;
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input int n, input bit first_done);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 2'b00, first_done && (i == 0));
    endtask

    task automatic push_beep(input logic [1:0] code, input int n, input int half);
        for (int i = 0; i < n; i++) push(((i / half) % 2) == 0, 1'b1, code, 1'b0);
    endtask

    task automatic push_gap(input int n, input bit first_done);
        for (int i = 0; i < n; i++) push(1'b0, 1'b1, 2'b00, first_done && (i == 0));
    endtask

    task automatic begin_scn(input string name);
        tag  = name;
        step = 0;
    endtask

    task automatic sb_check();
        exp_t e;
        exp_t got;
        got = {buzzer, busy, beep_kind, done};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s step %0d: scoreboard empty, got %b", tag, step, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s step %0d: got buzzer=%b busy=%b kind=%b done=%b, want buzzer=%b busy=%b kind=%b done=%b",
                         tag, step, got.buzzer, got.busy, got.kind, got.done,
                         e.buzzer, e.busy, e.kind, e.done);
            end
        end
        step++;
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({buzzer, busy, beep_kind, done} !== 5'b0) begin
            errors++;
            $display("FAIL %s: got buzzer=%b busy=%b kind=%b done=%b, want all zero",
                     name, buzzer, busy, beep_kind, done);
        end
    endtask

    // Each cycle: drive after the rising edge, compare on the falling edge.
    task automatic drive(input logic [1:0] bee, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 bee_in = bee;
            @(negedge clk);
            sb_check();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{code: 2'b01, hold: 100, total: 110, dur: SHORT_CYC, half: LO_HALF, kind: 2'b01};
        vecs[1] = '{code: 2'b10, hold: 20,  total: 60,  dur: LONG_CYC,  half: HI_HALF, kind: 2'b10};
        vecs[2] = '{code: 2'b11, hold: 10,  total: 15,  dur: 0,         half: 1,       kind: 2'b00};
        vecs[3] = '{code: 2'b01, hold: 1,   total: 40,  dur: SHORT_CYC, half: LO_HALF, kind: 2'b01};

        // Reset held with a long request present.
        rst_n  = 1'b0;
        bee_in = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_zero("reset_hold");
        end

        // Release: bee_q is 00, so the held 10 triggers in the release cycle.
        begin_scn("reset_release");
        push_idle(1, 0);
        push_beep(2'b10, LONG_CYC, HI_HALF);
        push_idle(1, 1);
        push_idle(8, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        sb_check();
        drive(2'b10, 19);
        drive(2'b00, 40);

        // Table vectors: code held for 'hold' cycles out of 'total'.
        for (int v = 0; v < 4; v++) begin
            begin_scn($sformatf("vec%0d", v));
            push_idle(1, 0);
            if (vecs[v].dur > 0) begin
                push_beep(vecs[v].kind, vecs[v].dur, vecs[v].half);
                push_idle(1, 1);
                push_idle(vecs[v].total - vecs[v].dur - 2, 0);
            end else begin
                push_idle(vecs[v].total - 1, 0);
            end
            drive(vecs[v].code, vecs[v].hold);
            drive(2'b00, vecs[v].total - vecs[v].hold);
        end

        // Long request 10 cycles into a short beep restarts as long, no done for the short.
        begin_scn("preempt");
        push_idle(1, 0);
        push_beep(2'b01, 10, LO_HALF);
        push_beep(2'b10, LONG_CYC, HI_HALF);
        push_idle(1, 1);
        push_idle(5, 0);
        drive(2'b01, 10);
        drive(2'b10, 20);
        drive(2'b00, 37);

        // 01 and 11 during a long beep change nothing.
        begin_scn("ignore");
        push_idle(1, 0);
        push_beep(2'b10, LONG_CYC, HI_HALF);
        push_idle(1, 1);
        push_idle(5, 0);
        drive(2'b10, 5);
        drive(2'b01, 5);
        drive(2'b11, 5);
        drive(2'b00, 42);

        // 01 -> 00 -> 01 mid-beep restarts the short beep.
        begin_scn("retrigger");
        push_idle(1, 0);
        push_beep(2'b01, 7, LO_HALF);
        push_beep(2'b01, SHORT_CYC, LO_HALF);
        push_idle(1, 1);
        push_idle(5, 0);
        drive(2'b01, 5);
        drive(2'b00, 2);
        drive(2'b01, 1);
        drive(2'b00, 36);

        // Trigger in the done cycle starts the next beep immediately after.
        begin_scn("done_cycle_trigger");
        push_idle(1, 0);
        push_beep(2'b01, SHORT_CYC, LO_HALF);
        push_idle(1, 1);
        push_beep(2'b10, LONG_CYC, HI_HALF);
        push_idle(1, 1);
        push_idle(5, 0);
        drive(2'b01, 1);
        drive(2'b00, 30);
        drive(2'b10, 1);
        drive(2'b00, 56);

        // Reset asserted mid-beep while the buzzer is high silences it at once.
        begin_scn("reset_mid");
        push_idle(1, 0);
        push_beep(2'b10, 6, HI_HALF);
        drive(2'b10, 1);
        drive(2'b00, 6);
        #1 rst_n = 1'b0;
        #1 check_zero("reset_async");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        begin_scn("after_reset");
        push_idle(4, 0);
        drive(2'b00, 4);

`ifdef BEEP_REPEAT_EN
        // Held 10: beep / gap / beep, then drop during the second gap.
        begin_scn("repeat");
        push_idle(1, 0);
        push_beep(2'b10, LONG_CYC, HI_HALF);
        push_gap(GAP_CYC, 1);
        push_beep(2'b10, LONG_CYC, HI_HALF);
        push_gap(6, 1);
        push_idle(4, 0);
        drive(2'b10, 126);
        drive(2'b00, 5);
`endif

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
